// File: rtl/decoder_scan.sv
// Registered N-to-2^N line decoder with enable, output polarity and prescaled auto-scan.
// Latency 1 cycle from inputs to line/cur_sel/wrap; no backpressure, outputs update on every edge.
module decoder_scan #(
    parameter int SEL_W      = 2,
    localparam int OUT_W     = 2 ** SEL_W,
    parameter int N_LINES    = 2 ** SEL_W,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] line,
    output logic [SEL_W-1:0] cur_sel,
    output logic             wrap
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_LINES - 1);
    localparam logic [OUT_W-1:0] IDLE     = {OUT_W{ACTIVE_LOW}};

    logic [OUT_W-1:0] line_q,    line_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [PRE_W-1:0] pre_q,     pre_d;
    logic             wrap_q,    wrap_d;
    logic             step;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] k);
        onehot = OUT_W'(1) << k;
    endfunction

    assign step = (pre_q == PRE_MAX);

    always_comb begin
        cur_sel_d = cur_sel_q;
        pre_d     = pre_q;
        wrap_d    = 1'b0;
        line_d    = IDLE;

        if (!en) begin
            // lines go idle, counters freeze so the scan resumes where it left off
            cur_sel_d = cur_sel_q;
        end else if (!mode) begin
            cur_sel_d = sel;
            pre_d     = '0;
            line_d    = onehot(sel) ^ IDLE;
        end else begin
            pre_d = step ? '0 : pre_q + 1'b1;
            if (cur_sel_q > LAST_SEL) begin
                // a direct-mode select beyond the scan range restarts the scan at line 0
                cur_sel_d = '0;
            end else if (step) begin
                if (cur_sel_q == LAST_SEL) begin
                    cur_sel_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    cur_sel_d = cur_sel_q + 1'b1;
                end
            end
            line_d = onehot(cur_sel_d) ^ IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q    <= IDLE;
            cur_sel_q <= '0;
            pre_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            line_q    <= line_d;
            cur_sel_q <= cur_sel_d;
            pre_q     <= pre_d;
            wrap_q    <= wrap_d;
        end
    end

    assign line    = line_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst, en, mode;
    logic [1:0] sel;
    logic [3:0] line_a, line_b;
    logic [1:0] cur_a, cur_b;
    logic       wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] line;
        logic [1:0] cur;
        logic       wrap;
        logic       chk_b;
        logic [3:0] line_b;
    } exp_t;

    exp_t exp_q[$];
    int   vec_n = 0;

    always #5 clk = ~clk;

    // scan-checked instance: 3 lines, step every 3 cycles, active-high
    decoder_scan #(.SEL_W(2), .N_LINES(3), .DIV(3), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .line(line_a), .cur_sel(cur_a), .wrap(wrap_a)
    );

    // polarity instance: checked only in reset and direct phases
    decoder_scan #(.SEL_W(2), .N_LINES(4), .DIV(4), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .line(line_b), .cur_sel(cur_b), .wrap(wrap_b)
    );

    task automatic vec(input logic r, input logic e, input logic m, input logic [1:0] s,
                       input logic [3:0] xl, input logic [1:0] xc, input logic xw,
                       input logic cb, input logic [3:0] xlb);
        exp_t x;
        rst  = r;
        en   = e;
        mode = m;
        sel  = s;
        @(posedge clk);
        x.line   = xl;
        x.cur    = xc;
        x.wrap   = xw;
        x.chk_b  = cb;
        x.line_b = xlb;
        exp_q.push_back(x);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n++;
                checks++;
                if (line_a !== x.line) begin
                    errors++;
                    $display("FAIL line_a vec %0d got %b want %b", n, line_a, x.line);
                end
                checks++;
                if (cur_a !== x.cur) begin
                    errors++;
                    $display("FAIL cur_sel_a vec %0d got %0d want %0d", n, cur_a, x.cur);
                end
                checks++;
                if (wrap_a !== x.wrap) begin
                    errors++;
                    $display("FAIL wrap_a vec %0d got %b want %b", n, wrap_a, x.wrap);
                end
                if (x.chk_b) begin
                    checks++;
                    if (line_b !== x.line_b) begin
                        errors++;
                        $display("FAIL line_b vec %0d got %b want %b", n, line_b, x.line_b);
                    end
                    checks++;
                    if (cur_b !== x.cur) begin
                        errors++;
                        $display("FAIL cur_sel_b vec %0d got %0d want %0d", n, cur_b, x.cur);
                    end
                    checks++;
                    if (wrap_b !== 1'b0) begin
                        errors++;
                        $display("FAIL wrap_b vec %0d got %b want 0", n, wrap_b);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd3;
        //   rst  en   mode sel    line     cur  wrap  chk_b line_b
        // reset overrides en/mode
        vec(1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 2'd0, 1'b0, 1'b1, 4'b1111);
        vec(1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 2'd0, 1'b0, 1'b1, 4'b1111);
        // direct sweep, sel=3 decodes although beyond N_LINES
        vec(1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b1110);
        vec(1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b1101);
        vec(1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0, 1'b1, 4'b1011);
        vec(1'b0, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0, 1'b1, 4'b0111);
        // enter scan with cur_sel=3: clamp to 0, first step 3 edges in
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000);
        // step 2 -> 0 carries the single wrap pulse
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        // en=0 for 5 cycles with cur_sel=1, prescaler=1
        for (int i = 0; i < 5; i++)
            vec(1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000);
        // reset mid-scan at cur_sel=2, prescaler=1; no wrap afterwards
        vec(1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        // scan -> direct, en gating in direct mode
        vec(1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0, 1'b1, 4'b1011);
        vec(1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 2'd2, 1'b0, 1'b1, 4'b1111);
        vec(1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b1101);
        // back to scan: prescaler was cleared, step after 3 edges
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0000);
        vec(1'b0, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
